// File: rtl/variance_cache_fill_if.sv
// Bus bundle between the variance-cache fill block and its environment:
// window feed, integral-memory read port, normaliser hand-off and corner read ports.
interface variance_cache_fill_if #(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned II_W   = 32,
   parameter int unsigned SQ_W   = 48
);
   logic              win_valid;
   logic              win_ready;
   logic [15:0]       win_x;
   logic [15:0]       win_y;

   logic              ii_rd_en;
   logic [ADDR_W-1:0] ii_raddr;
   logic [II_W-1:0]   ii_q;
   logic [SQ_W-1:0]   ii_qSQ;

   logic              cons_ready;
   logic              cons_start;
   logic              cons_dblBuf;
   logic              cons_valid;
   logic              cons_taken;

   logic [2:0]        rdA_raddr;
   logic [2:0]        rdB_raddr;
   logic [II_W-1:0]   rdA_q;
   logic [II_W-1:0]   rdB_q;
   logic [SQ_W-1:0]   rdA_qSQ;
   logic [SQ_W-1:0]   rdB_qSQ;

   modport master (
      input  win_valid, win_x, win_y, ii_q, ii_qSQ, cons_ready, cons_valid,
             rdA_raddr, rdB_raddr,
      output win_ready, ii_rd_en, ii_raddr, cons_start, cons_dblBuf, cons_taken,
             rdA_q, rdB_q, rdA_qSQ, rdB_qSQ
   );

   modport slave (
      output win_valid, win_x, win_y, ii_q, ii_qSQ, cons_ready, cons_valid,
             rdA_raddr, rdB_raddr,
      input  win_ready, ii_rd_en, ii_raddr, cons_start, cons_dblBuf, cons_taken,
             rdA_q, rdB_q, rdA_qSQ, rdB_qSQ
   );
endinterface

// File: rtl/variance_cache_fill.sv
// Fetches the four integral/squared-integral corners of each detection window into a
// double-buffered corner cache and hands filled banks to the variance normaliser in order.
module variance_cache_fill #(
   parameter int unsigned IMG_WIDTH = 320,
   parameter int unsigned ADDR_W    = 17,
   parameter int unsigned II_W      = 32,
   parameter int unsigned SQ_W      = 48,
   parameter int unsigned WIN       = 24,
   parameter int unsigned RD_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   variance_cache_fill_if.master bus
);

   localparam logic [1:0] F_IDLE  = 2'd0;
   localparam logic [1:0] F_ISSUE = 2'd1;
   localparam logic [1:0] F_DRAIN = 2'd2;

   localparam logic [0:0] H_IDLE  = 1'b0;
   localparam logic [0:0] H_BUSY  = 1'b1;

   // Corner k: bit0 selects the right column, bit1 the bottom row.
   function automatic logic [ADDR_W-1:0] corner_addr(input logic [15:0] x,
                                                    input logic [15:0] y,
                                                    input logic [1:0]  k);
      logic [31:0] col;
      logic [31:0] row;
      col = 32'(x) + (k[0] ? 32'(WIN) : 32'd0);
      row = 32'(y) + (k[1] ? 32'(WIN) : 32'd0);
      return ADDR_W'(row * 32'(IMG_WIDTH) + col);
   endfunction

   logic [1:0]              fstate_q, fstate_d;
   logic [0:0]              hstate_q, hstate_d;
   logic [15:0]             x_q, x_d;
   logic [15:0]             y_q, y_d;
   logic                    rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]       raddr_q, raddr_d;
   logic [1:0]              rd_k_q, rd_k_d;
   logic [RD_LAT-1:0]       pipe_v_q, pipe_v_d;
   logic [RD_LAT-1:0][1:0]  pipe_k_q, pipe_k_d;
   logic                    last_wr_q, last_wr_d;
   logic [1:0]              full_q, full_d;
   logic                    wsel_q, wsel_d;
   logic                    rsel_q, rsel_d;
   logic                    win_ready_q, win_ready_d;
   logic                    start_q, start_d;
   logic                    dblbuf_q, dblbuf_d;
   logic                    taken_q, taken_d;
   logic [II_W-1:0]         bq_q  [2][4];
   logic [SQ_W-1:0]         bsq_q [2][4];

   logic                    set_full;
   logic                    clr_full;
   logic                    wr_en;
   logic [1:0]              wr_k;

   assign wr_en = pipe_v_q[RD_LAT-1];
   assign wr_k  = pipe_k_q[RD_LAT-1];

   // Fill FSM: accept a window, issue four corner reads, wait for the last return.
   always_comb begin
      fstate_d = fstate_q;
      x_d      = x_q;
      y_d      = y_q;
      rd_en_d  = 1'b0;
      raddr_d  = raddr_q;
      rd_k_d   = rd_k_q;
      wsel_d   = wsel_q;
      set_full = 1'b0;
      case (fstate_q)
         F_IDLE: begin
            if (bus.win_valid && win_ready_q) begin
               x_d      = bus.win_x;
               y_d      = bus.win_y;
               rd_en_d  = 1'b1;
               rd_k_d   = 2'd0;
               raddr_d  = corner_addr(bus.win_x, bus.win_y, 2'd0);
               fstate_d = F_ISSUE;
            end
         end
         F_ISSUE: begin
            if (rd_k_q != 2'd3) begin
               rd_en_d = 1'b1;
               rd_k_d  = rd_k_q + 2'd1;
               raddr_d = corner_addr(x_q, y_q, rd_k_q + 2'd1);
            end else begin
               fstate_d = F_DRAIN;
            end
         end
         F_DRAIN: begin
            if (last_wr_q) begin
               set_full = 1'b1;
               wsel_d   = ~wsel_q;
               fstate_d = F_IDLE;
            end
         end
         default: fstate_d = F_IDLE;
      endcase
   end

   // Read-return tracking: one valid/corner-index stage per cycle of memory latency.
   always_comb begin
      pipe_v_d    = pipe_v_q;
      pipe_k_d    = pipe_k_q;
      pipe_v_d[0] = rd_en_q;
      pipe_k_d[0] = rd_k_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         pipe_k_d[i] = pipe_k_q[i-1];
      end
      last_wr_d = wr_en && (wr_k == 2'd3);
   end

   // Hand-off FSM: one start per full bank, one taken per consumer completion.
   always_comb begin
      hstate_d = hstate_q;
      start_d  = 1'b0;
      taken_d  = 1'b0;
      dblbuf_d = dblbuf_q;
      rsel_d   = rsel_q;
      clr_full = 1'b0;
      case (hstate_q)
         H_IDLE: begin
            if (full_q[rsel_q] && bus.cons_ready) begin
               start_d  = 1'b1;
               dblbuf_d = rsel_q;
               hstate_d = H_BUSY;
            end
         end
         H_BUSY: begin
            if (bus.cons_valid) begin
               taken_d  = 1'b1;
               clr_full = 1'b1;
               rsel_d   = ~rsel_q;
               hstate_d = H_IDLE;
            end
         end
         default: hstate_d = H_IDLE;
      endcase
   end

   // Set and clear always target different banks: a bank is only filled while empty.
   always_comb begin
      full_d = full_q;
      if (set_full) full_d[wsel_q] = 1'b1;
      if (clr_full) full_d[rsel_q] = 1'b0;
      win_ready_d = (fstate_d == F_IDLE) && !full_d[wsel_d];
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fstate_q    <= F_IDLE;
         hstate_q    <= H_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         rd_en_q     <= 1'b0;
         raddr_q     <= '0;
         rd_k_q      <= '0;
         pipe_v_q    <= '0;
         pipe_k_q    <= '0;
         last_wr_q   <= 1'b0;
         full_q      <= '0;
         wsel_q      <= 1'b0;
         rsel_q      <= 1'b0;
         win_ready_q <= 1'b0;
         start_q     <= 1'b0;
         dblbuf_q    <= 1'b0;
         taken_q     <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < 4; e++) begin
               bq_q[b][e]  <= '0;
               bsq_q[b][e] <= '0;
            end
         end
      end else begin
         fstate_q    <= fstate_d;
         hstate_q    <= hstate_d;
         x_q         <= x_d;
         y_q         <= y_d;
         rd_en_q     <= rd_en_d;
         raddr_q     <= raddr_d;
         rd_k_q      <= rd_k_d;
         pipe_v_q    <= pipe_v_d;
         pipe_k_q    <= pipe_k_d;
         last_wr_q   <= last_wr_d;
         full_q      <= full_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         win_ready_q <= win_ready_d;
         start_q     <= start_d;
         dblbuf_q    <= dblbuf_d;
         taken_q     <= taken_d;
         if (wr_en) begin
            bq_q[wsel_q][wr_k]  <= bus.ii_q;
            bsq_q[wsel_q][wr_k] <= bus.ii_qSQ;
         end
      end
   end

   assign bus.win_ready   = win_ready_q;
   assign bus.ii_rd_en    = rd_en_q;
   assign bus.ii_raddr    = raddr_q;
   assign bus.cons_start  = start_q;
   assign bus.cons_dblBuf = dblbuf_q;
   assign bus.cons_taken  = taken_q;

   // Consumer read ports: entries 1..4 map to corners, anything else reads zero.
   always_comb begin
      bus.rdA_q   = '0;
      bus.rdA_qSQ = '0;
      bus.rdB_q   = '0;
      bus.rdB_qSQ = '0;
      if (bus.rdA_raddr >= 3'd1 && bus.rdA_raddr <= 3'd4) begin
         bus.rdA_q   = bq_q[0][2'(bus.rdA_raddr - 3'd1)];
         bus.rdA_qSQ = bsq_q[0][2'(bus.rdA_raddr - 3'd1)];
      end
      if (bus.rdB_raddr >= 3'd1 && bus.rdB_raddr <= 3'd4) begin
         bus.rdB_q   = bq_q[1][2'(bus.rdB_raddr - 3'd1)];
         bus.rdB_qSQ = bsq_q[1][2'(bus.rdB_raddr - 3'd1)];
      end
   end

endmodule

// File: doc/variance_cache_fill.md
Name: variance_cache_fill

Overview:
- Producer side of the variance-cache read interface: for each detection-window position, fetches the four corner values of the integral image and the squared integral image, and stores them in a double-buffered 4-entry corner cache (bank A/B).
- Hands each filled bank to the variance normaliser using its start/ready/dblBuf/valid/taken handshake.
- Serves that consumer's combinational reads on two read ports (A, B).
- Sits between the integral-image caches and the variance normaliser in the window-scan pipeline.

Parameters:
- IMG_WIDTH, 320: integral-image row pitch in entries.
- ADDR_W, 17: integral-image memory address width.
- II_W, 32: integral-image word width (q).
- SQ_W, 48: squared-integral word width (qSQ).
- WIN, 24: window side length in pixels.
- RD_LAT, 2: integral-memory read latency in cycles (1..4).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- win_valid  in  1  window position offered
- win_ready  out  1  position accepted when win_valid & win_ready
- win_x  in  16  window top-left column
- win_y  in  16  window top-left row
- ii_rd_en  out  1  integral-memory read strobe
- ii_raddr  out  ADDR_W  integral-memory address (same address for both images)
- ii_q  in  II_W  integral data, RD_LAT cycles after the strobe
- ii_qSQ  in  SQ_W  squared-integral data, same timing as ii_q
- cons_ready  in  1  consumer idle
- cons_start  out  1  one-cycle pulse: bank handed to consumer
- cons_dblBuf  out  1  bank handed over (0=A, 1=B); held stable until the next start
- cons_valid  in  1  consumer finished; result valid
- cons_taken  out  1  one-cycle acknowledge of cons_valid
- rdA_raddr, rdB_raddr  in  3  read address, port A / port B
- rdA_q, rdB_q  out  II_W  corner integral value
- rdA_qSQ, rdB_qSQ  out  SQ_W  corner squared value
- Read ports ignore their SQ address; raddr selects both q and qSQ.

Behaviour:
- Reset (resetn low at a clock edge):
  - Both banks empty, all entries 0.
  - Fill FSM to IDLE; wsel=0, rsel=0.
  - win_ready=0 during reset, ii_rd_en=0, cons_start=0, cons_dblBuf=0, cons_taken=0.
  - Read-return pipeline flushed; returns from reads issued before reset are discarded.
  - Reset mid-fill or mid-consume abandons all work.
- Corner mapping, address 1..4:
  - Entry 1 = TL at (x,y).
  - Entry 2 = TR at (x+WIN,y).
  - Entry 3 = BL at (x,y+WIN).
  - Entry 4 = BR at (x+WIN,y+WIN).
  - Memory address = row*IMG_WIDTH + col, truncated to ADDR_W; no bounds check.
  - The consumer then computes E1-E2-E3+E4.
- Fill FSM states:
  - IDLE: win_ready = ~full[wsel]. On accept, latch x,y and go to ISSUE.
  - ISSUE: 4 consecutive cycles with ii_rd_en=1 and addresses TL, TR, BL, BR; corner index k=1..4 tracked internally. Then go to DRAIN.
  - DRAIN: wait until the 4th return is written. Then set full[wsel], toggle wsel, go to IDLE.
  - Returns are tracked by a RD_LAT-deep valid/index shift register. Each return writes ii_q/ii_qSQ into bank wsel at entry k.
  - Accept-to-bank-full latency: 4+RD_LAT+1 cycles.
- Hand-off FSM states:
  - HIDLE: when full[rsel] & cons_ready, pulse cons_start, drive cons_dblBuf=rsel, go to BUSY.
  - BUSY: on cons_valid, pulse cons_taken for 1 cycle, clear full[rsel], toggle rsel, return to HIDLE.
  - cons_taken is not re-asserted while cons_valid stays high in the same busy period.
  - Banks are consumed strictly in fill order.
- Read ports:
  - Combinational: q/qSQ = bank[port][raddr].
  - Port A always reads bank A; port B always reads bank B.
  - raddr 0, 5, 6, 7 return 0.
  - Reading a bank during its fill returns the partially written contents (no stall).
- Simultaneous events:
  - A bank freed in the same cycle the fill FSM samples full[wsel] is seen as empty the next cycle.
  - A bank completing fill in the same cycle hand-off checks full[rsel] is handed off the next cycle.
  - Fill and consume of opposite banks proceed concurrently.
- Both banks full: win_ready=0 until a cons_taken frees one.

Test Plan:
- Reset, then window (x=0, y=0), memory returning data = address: after 4+RD_LAT+1 cycles, bank A = {0, 24, 7680, 7704}. Then cons_start pulses with dblBuf=0. Port A at raddr=4 reads 7704.
- Two back-to-back windows (0,0) and (1,0), consumer not ready: bank A then bank B fill. Third window sees win_ready=0 until cons_taken. Hand-off order is A then B.
- cons_valid held high 3 cycles: exactly one cons_taken pulse; rsel toggles once.
- Reset asserted at ISSUE corner 2: in-flight returns discarded, banks read 0, win_ready=1 one cycle after release.
- raddr=0 and raddr=7 on either port: q=0, qSQ=0.
- qSQ path: ii_qSQ = 2^40+addr → entry 4 qSQ = 2^40+7704 (full SQ_W width preserved).
